// File: rtl/tail_light_pkg.sv
// Shared types and helpers for the tail-light sequencer.
// Holds the state encoding and the thermometer pattern builder.
package tail_light_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEQ_L,
      SEQ_R,
      SEQ_LR,
      HAZ_ON,
      HAZ_OFF
   } state_t;

   localparam int unsigned MAX_LAMPS = 32;

   // Lamps 0..pos-1 lit; callers truncate to their own bank width.
   function automatic logic [MAX_LAMPS-1:0] therm(input int unsigned pos);
      logic [MAX_LAMPS-1:0] pat;
      pat = '0;
      for (int unsigned i = 0; i < MAX_LAMPS; i++) begin
         if (i < pos) pat[i] = 1'b1;
      end
      return pat;
   endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step-rate prescaler: pulses step once every STEP_CYCLES clocks.
// clr restarts the count so a newly entered state gets a full step period.
module step_prescaler #(
   parameter int STEP_CYCLES = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic step
);

   localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(STEP_CYCLES - 1);

   logic [TW-1:0] tick_cnt;

   always_ff @(posedge clk) begin
      if (reset || clr || step) tick_cnt <= '0;
      else                      tick_cnt <= tick_cnt + 1'b1;
   end

   assign step = (tick_cnt == TICK_LAST);

endmodule

// File: rtl/tail_light_seq.sv
// Turn / hazard / brake lamp sequencer for a left and a right lamp bank.
// Lamp outputs are decoded from the next state and registered, so inputs show one cycle later.
module tail_light_seq
   import tail_light_pkg::*;
#(
   parameter int N_LAMPS     = 3,
   parameter int STEP_CYCLES = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               left,
   input  logic               right,
   input  logic               hazard,
   input  logic               brake,
   output logic [N_LAMPS-1:0] lamps_l,
   output logic [N_LAMPS-1:0] lamps_r,
   output logic               busy
);

   localparam int PW = $clog2(N_LAMPS + 1);
   localparam logic [PW-1:0]      POS_LAST = PW'(N_LAMPS);
   localparam logic [N_LAMPS-1:0] ALL_ON   = '1;

   state_t             state, state_nxt;
   logic [PW-1:0]      pos, pos_nxt;
   logic               step, clr;
   logic [N_LAMPS-1:0] pattern, brake_mask, lamps_l_nxt, lamps_r_nxt;

   step_prescaler #(.STEP_CYCLES(STEP_CYCLES)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .step  (step)
   );

   assign clr = (state_nxt != state);

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_nxt = state;
      pos_nxt   = pos;
      if (hazard) begin
         pos_nxt = '0;
         if (state == HAZ_ON) begin
            if (step) state_nxt = HAZ_OFF;
         end else if (state == HAZ_OFF) begin
            if (step) state_nxt = HAZ_ON;
         end else begin
            state_nxt = HAZ_ON;
         end
      end else begin
         case (state)
            IDLE: begin
               if (left || right) begin
                  pos_nxt   = PW'(1);
                  state_nxt = (left && right) ? SEQ_LR : (left ? SEQ_L : SEQ_R);
               end
            end
            SEQ_L, SEQ_R, SEQ_LR: begin
               if (step) begin
                  if (pos < POS_LAST) begin
                     pos_nxt = pos + PW'(1);
                  end else begin
                     state_nxt = IDLE;
                     pos_nxt   = '0;
                  end
               end
            end
            default: begin
               // Hazard released: an interrupted turn is dropped, never resumed.
               state_nxt = IDLE;
               pos_nxt   = '0;
            end
         endcase
      end
   end

   always_comb begin
      pattern     = N_LAMPS'(therm(32'(pos_nxt)));
      brake_mask  = brake ? ALL_ON : '0;
      lamps_l_nxt = brake_mask;
      lamps_r_nxt = brake_mask;
      case (state_nxt)
         SEQ_L:   lamps_l_nxt = pattern;
         SEQ_R:   lamps_r_nxt = pattern;
         SEQ_LR: begin
            lamps_l_nxt = pattern;
            lamps_r_nxt = pattern;
         end
         HAZ_ON: begin
            lamps_l_nxt = ALL_ON;
            lamps_r_nxt = ALL_ON;
         end
         HAZ_OFF: begin
            lamps_l_nxt = '0;
            lamps_r_nxt = '0;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         pos     <= '0;
         lamps_l <= '0;
         lamps_r <= '0;
         busy    <= 1'b0;
      end else begin
         state   <= state_nxt;
         pos     <= pos_nxt;
         lamps_l <= lamps_l_nxt;
         lamps_r <= lamps_r_nxt;
         busy    <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_tail_light_seq.sv
// Self-checking bench: three sequencer configurations share one stimulus stream
// and are compared every cycle against a time-based behavioural model.
module tb_tail_light_seq;

   localparam int NI = 3;

   logic clk = 1'b0;
   logic reset, left, right, hazard, brake;

   always #5 clk = ~clk;

   logic [2:0] l0, r0;
   logic       b0;
   logic [3:0] l1, r1;
   logic       b1;
   logic [2:0] l2, r2;
   logic       b2;

   tail_light_seq #(.N_LAMPS(3), .STEP_CYCLES(1)) u0 (
      .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard), .brake(brake),
      .lamps_l(l0), .lamps_r(r0), .busy(b0));
   tail_light_seq #(.N_LAMPS(4), .STEP_CYCLES(3)) u1 (
      .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard), .brake(brake),
      .lamps_l(l1), .lamps_r(r1), .busy(b1));
   tail_light_seq #(.N_LAMPS(3), .STEP_CYCLES(2)) u2 (
      .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard), .brake(brake),
      .lamps_l(l2), .lamps_r(r2), .busy(b2));

   logic [3:0] obs_l [NI];
   logic [3:0] obs_r [NI];
   logic       obs_b [NI];

   always_comb begin
      obs_l[0] = {1'b0, l0};
      obs_r[0] = {1'b0, r0};
      obs_b[0] = b0;
      obs_l[1] = l1;
      obs_r[1] = r1;
      obs_b[1] = b1;
      obs_l[2] = {1'b0, l2};
      obs_r[2] = {1'b0, r2};
      obs_b[2] = b2;
   end

   int n_checks = 0;
   int n_errors = 0;

   // Model: mode 0 idle, 1 left, 2 right, 3 both, 4 hazard; age = cycles since mode entry.
   int nl   [NI];
   int sc   [NI];
   int mode [NI];
   int age  [NI];
   bit in_reset;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] ones(input int k);
      return 4'((1 << k) - 1);
   endfunction

   task automatic model_step();
      for (int i = 0; i < NI; i++) begin
         if (reset) begin
            mode[i] = 0;
            age[i]  = 0;
         end else if (hazard) begin
            if (mode[i] == 4) age[i]++;
            else begin
               mode[i] = 4;
               age[i]  = 0;
            end
         end else if (mode[i] == 4) begin
            mode[i] = 0;
            age[i]  = 0;
         end else if (mode[i] != 0) begin
            age[i]++;
            if (age[i] == nl[i] * sc[i]) begin
               mode[i] = 0;
               age[i]  = 0;
            end
         end else if (left || right) begin
            mode[i] = (left && right) ? 3 : (left ? 1 : 2);
            age[i]  = 0;
         end
      end
      in_reset = reset;
   endtask

   task automatic expect_out(input int i, output logic [3:0] el, output logic [3:0] er,
                             output logic eb);
      logic [3:0] full, bk, pat;
      full = ones(nl[i]);
      bk   = brake ? full : 4'h0;
      pat  = ones(age[i] / sc[i] + 1);
      el   = bk;
      er   = bk;
      eb   = (mode[i] != 0);
      if (in_reset) begin
         el = 4'h0;
         er = 4'h0;
         eb = 1'b0;
      end else begin
         case (mode[i])
            1: el = pat;
            2: er = pat;
            3: begin
               el = pat;
               er = pat;
            end
            4: begin
               el = ((age[i] / sc[i]) % 2 == 0) ? full : 4'h0;
               er = el;
            end
            default: ;
         endcase
      end
   endtask

   task automatic tick();
      logic [3:0] el, er;
      logic       eb;
      @(posedge clk);
      model_step();
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         expect_out(i, el, er, eb);
         check($sformatf("lamps_l[u%0d]", i), 32'(obs_l[i]), 32'(el));
         check($sformatf("lamps_r[u%0d]", i), 32'(obs_r[i]), 32'(er));
         check($sformatf("busy[u%0d]", i), 32'(obs_b[i]), 32'(eb));
      end
   endtask

   initial begin
      nl[0] = 3; sc[0] = 1;
      nl[1] = 4; sc[1] = 3;
      nl[2] = 3; sc[2] = 2;
      for (int i = 0; i < NI; i++) begin
         mode[i] = 0;
         age[i]  = 0;
      end
      in_reset = 1'b1;
      reset = 1'b1; left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b0;
      @(negedge clk);
      tick();
      tick();
      check("reset_busy", 32'(b1), 32'h0);
      reset = 1'b0;
      tick();

      // One-cycle left pulse on the fast unit: 001, 011, 111, then off.
      left = 1'b1;
      tick();
      check("t1_l_001", 32'(l0), 32'h1);
      check("t1_r_off", 32'(r0), 32'h0);
      left = 1'b0;
      tick();
      check("t1_l_011", 32'(l0), 32'h3);
      tick();
      check("t1_l_111", 32'(l0), 32'h7);
      check("t1_busy", 32'(b0), 32'h1);
      tick();
      check("t1_l_off", 32'(l0), 32'h0);
      check("t1_idle", 32'(b0), 32'h0);
      repeat (14) tick();

      // Right held: repeated sequences with an idle gap between them.
      right = 1'b1;
      tick();
      check("t2_r_0001", 32'(r1), 32'h1);
      repeat (3) tick();
      check("t2_r_0011", 32'(r1), 32'h3);
      repeat (40) tick();
      right = 1'b0;
      repeat (14) tick();

      // Both sides with brake applied mid-sequence.
      left = 1'b1; right = 1'b1;
      tick();
      brake = 1'b1;
      repeat (5) tick();
      left = 1'b0; right = 1'b0; brake = 1'b0;
      repeat (14) tick();

      // Hazard while u2 sits at pos=2 of a left sequence.
      left = 1'b1;
      tick();
      left = 1'b0;
      tick();
      tick();
      check("t4_l_pos2", 32'(l2), 32'h3);
      hazard = 1'b1;
      tick();
      check("t4_haz_l", 32'(l2), 32'h7);
      check("t4_haz_r", 32'(r2), 32'h7);
      repeat (9) tick();
      hazard = 1'b0;
      tick();
      check("t4_drop_l", 32'(l2), 32'h0);
      check("t4_drop_busy", 32'(b2), 32'h0);
      repeat (4) tick();

      // Brake during a left sequence, then brake alone in idle.
      brake = 1'b1; left = 1'b1;
      tick();
      check("t5_r_brake", 32'(r0), 32'h7);
      left = 1'b0;
      repeat (14) tick();
      brake = 1'b0;
      tick();
      brake = 1'b1;
      tick();
      check("t5_idle_l", 32'(l0), 32'h7);
      check("t5_idle_r", 32'(r1), 32'hf);
      brake = 1'b0;
      tick();

      // Reset mid right sequence, then held with left requested.
      right = 1'b1;
      tick();
      right = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("t6_r_off", 32'(r0), 32'h0);
      check("t6_busy", 32'(b0), 32'h0);
      left = 1'b1;
      repeat (3) tick();
      check("t6_held_busy", 32'(b2), 32'h0);
      reset = 1'b0; left = 1'b0;
      tick();

      // Randomized traffic.
      for (int k = 0; k < 4000; k++) begin
         reset = ($urandom_range(0, 99) == 0);
         if (hazard) hazard = ($urandom_range(0, 14) != 0);
         else        hazard = ($urandom_range(0, 59) == 0);
         left  = ($urandom_range(0, 3) == 0);
         right = ($urandom_range(0, 3) == 0);
         brake = ($urandom_range(0, 2) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
